// File: rtl/synmul_pkg.sv
// Shared constants and result type for the synthesized-multiplier accumulator.
package synmul_pkg;
  localparam int PROD_W      = 65;
  localparam int MUL_LATENCY = 4;
  // Widest accumulator the result struct can carry; ACC_W must not exceed it.
  localparam int ACC_MAX_W   = 128;

  typedef struct packed {
    logic [ACC_MAX_W-1:0] sum;
    logic                 ovf;
  } acc_result_t;
endpackage

// File: rtl/synmul_vld_dly.sv
// Enable delay line: marks the cycles on which the multiplier output is fresh.
module synmul_vld_dly
  import synmul_pkg::*;
#(
  parameter int LATENCY = MUL_LATENCY
) (
  input  logic clk,
  input  logic flush,
  input  logic d,
  output logic fresh
);
  logic [LATENCY-1:0] vld_sr;

  generate
    if (LATENCY == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (flush) vld_sr <= '0;
        else       vld_sr <= d;
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (flush) vld_sr <= '0;
        else       vld_sr <= {vld_sr[LATENCY-2:0], d};
      end
    end
  endgenerate

  assign fresh = vld_sr[LATENCY-1];
endmodule

// File: rtl/synmul_acc.sv
// Sums BATCH fresh multiplier products and hands each total out through a
// one-entry valid/ready register; the upstream multiplier is never stalled.
module synmul_acc
  import synmul_pkg::*;
#(
  parameter int LATENCY = MUL_LATENCY,
  parameter int BATCH   = 8,
  parameter int ACC_W   = 72,
  localparam int CNT_W  = $clog2(BATCH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [PROD_W-1:0] product_d4,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_ovf,
  output logic              drop_err,
  output logic [CNT_W-1:0]  acc_cnt
);
  logic              fresh;
  logic [ACC_W-1:0]  acc, acc_base, acc_n, addend;
  logic [ACC_W:0]    sum_ext;
  logic [CNT_W-1:0]  cnt_base, cnt_n;
  logic              ovf_run, ovf_base, ovf_step, ovf_final, ovf_n;
  logic              complete, free;
  acc_result_t       out_reg, out_load;

  synmul_vld_dly #(.LATENCY(LATENCY)) u_vld_dly (
    .clk  (clk),
    .flush(reset),
    .d    (enable),
    .fresh(fresh)
  );

  // clear restarts the batch first, so a coinciding fresh product opens the new one.
  always_comb begin
    acc_base  = clear ? '0 : acc;
    cnt_base  = clear ? '0 : acc_cnt;
    ovf_base  = clear ? 1'b0 : ovf_run;
    addend    = ACC_W'($signed(product_d4));
    sum_ext   = {acc_base[ACC_W-1], acc_base} + {addend[ACC_W-1], addend};
    ovf_step  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    ovf_final = ovf_base | ovf_step;
    complete  = fresh && (cnt_base == CNT_W'(BATCH - 1));
    free      = !out_valid || out_ready;

    acc_n = acc_base;
    cnt_n = cnt_base;
    ovf_n = ovf_base;
    if (fresh) begin
      if (complete) begin
        acc_n = '0;
        cnt_n = '0;
        ovf_n = 1'b0;
      end else begin
        acc_n = sum_ext[ACC_W-1:0];
        cnt_n = cnt_base + CNT_W'(1);
        ovf_n = ovf_final;
      end
    end

    out_load                = '0;
    out_load.sum[ACC_W-1:0] = sum_ext[ACC_W-1:0];
    out_load.ovf            = ovf_final;
  end

  // Handshake: a result moves on any edge with out_valid & out_ready; out_sum/out_ovf
  // hold while out_valid & !out_ready; a completed batch is dropped only if the
  // register is full and not being drained on that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      acc_cnt   <= '0;
      ovf_run   <= 1'b0;
      out_reg   <= '0;
      out_valid <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      acc     <= acc_n;
      acc_cnt <= cnt_n;
      ovf_run <= ovf_n;
      if (complete && free) begin
        out_reg   <= out_load;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (complete && !free) drop_err <= 1'b1;
    end
  end

  assign out_sum = out_reg.sum[ACC_W-1:0];
  assign out_ovf = out_reg.ovf;
endmodule

// File: tb/tb_synmul_acc.sv
// Directed bench for synmul_acc: a 72-bit and a 66-bit instance share stimulus
// and are compared every cycle against a batch-level arithmetic model.
module tb_synmul_acc;
  localparam int LAT   = 4;
  localparam int BATCH = 8;
  localparam int W0    = 72;
  localparam int W1    = 66;
  localparam logic [64:0] NEG = 65'h1_0000_0000_0000_0000;

  logic          clk, reset, enable, clear, out_ready;
  logic [64:0]   product_d4, mul_in;
  logic [64:0]   pipe [LAT];
  logic [W0-1:0] out_sum;
  logic [W1-1:0] out_sum66;
  logic          out_valid, out_ovf, drop_err;
  logic          out_valid66, out_ovf66, drop_err66;
  logic [3:0]    acc_cnt, acc_cnt66;

  int n_checks = 0;
  int n_errors = 0;

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // multiplier stand-in: LAT-stage pipe, product visible LAT edges after launch
  always @(posedge clk) begin
    pipe[0] <= mul_in;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign product_d4 = pipe[LAT-1];

  synmul_acc #(.LATENCY(LAT), .BATCH(BATCH), .ACC_W(W0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .product_d4(product_d4), .out_sum(out_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_ovf(out_ovf), .drop_err(drop_err),
    .acc_cnt(acc_cnt)
  );

  synmul_acc #(.LATENCY(LAT), .BATCH(BATCH), .ACC_W(W1)) dut66 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .product_d4(product_d4), .out_sum(out_sum66), .out_valid(out_valid66),
    .out_ready(out_ready), .out_ovf(out_ovf66), .drop_err(drop_err66),
    .acc_cnt(acc_cnt66)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic signed [127:0] wrapw(input logic signed [127:0] v, input int w);
    logic signed [127:0] t;
    t = v <<< (128 - w);
    return t >>> (128 - w);
  endfunction

  // ---------------- behavioural model ----------------
  int                  edge_n = 0;
  int                  due_q[$];
  bit                  model_on = 0;
  logic signed [127:0] m_acc[2], m_sum[2], m_res[2];
  logic                m_ovf[2], m_oovf[2], m_ob[2];
  int                  m_cnt;
  logic                m_valid, m_drop;
  logic                m_fresh, m_done, m_free;
  logic signed [127:0] m_add, m_ex;
  int                  m_w;

  always @(posedge clk) begin
    edge_n++;
    m_fresh = 1'b0;
    if (due_q.size() > 0 && due_q[0] == edge_n) begin
      m_fresh = 1'b1;
      void'(due_q.pop_front());
    end
    if (reset) begin
      due_q.delete();
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = '0; m_sum[k] = '0; m_ovf[k] = 1'b0; m_oovf[k] = 1'b0;
      end
      m_cnt = 0; m_valid = 1'b0; m_drop = 1'b0;
      model_on = 1;
    end else begin
      if (enable) due_q.push_back(edge_n + LAT);
      if (clear) begin
        for (int k = 0; k < 2; k++) begin m_acc[k] = '0; m_ovf[k] = 1'b0; end
        m_cnt = 0;
      end
      m_done = 1'b0;
      m_free = !m_valid || out_ready;
      if (m_fresh) begin
        m_add = 128'($signed(product_d4));
        for (int k = 0; k < 2; k++) begin
          m_w      = (k == 0) ? W0 : W1;
          m_ex     = m_acc[k] + m_add;
          m_res[k] = wrapw(m_ex, m_w);
          m_ob[k]  = m_ovf[k] || (m_res[k] != m_ex);
        end
        if (m_cnt == BATCH - 1) begin
          m_done = 1'b1;
          m_cnt  = 0;
          for (int k = 0; k < 2; k++) begin m_acc[k] = '0; m_ovf[k] = 1'b0; end
        end else begin
          m_cnt++;
          for (int k = 0; k < 2; k++) begin m_acc[k] = m_res[k]; m_ovf[k] = m_ob[k]; end
        end
      end
      if (m_done && m_free) begin
        for (int k = 0; k < 2; k++) begin m_sum[k] = m_res[k]; m_oovf[k] = m_ob[k]; end
        m_valid = 1'b1;
      end else begin
        if (m_done) m_drop = 1'b1;
        if (m_valid && out_ready) m_valid = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_on) begin
      chk("cnt",     128'(acc_cnt),     128'(m_cnt));
      chk("cnt66",   128'(acc_cnt66),   128'(m_cnt));
      chk("valid",   128'(out_valid),   128'(m_valid));
      chk("valid66", 128'(out_valid66), 128'(m_valid));
      chk("drop",    128'(drop_err),    128'(m_drop));
      chk("drop66",  128'(drop_err66),  128'(m_drop));
      chk("sum",     128'(out_sum),     128'(m_sum[0][W0-1:0]));
      chk("sum66",   128'(out_sum66),   128'(m_sum[1][W1-1:0]));
      chk("ovf",     128'(out_ovf),     128'(m_oovf[0]));
      chk("ovf66",   128'(out_ovf66),   128'(m_oovf[1]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; clear = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic issue(input logic [64:0] v);
    enable = 1'b1;
    mul_in = v;
    tick();
    enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_valid(input int budget);
    int i;
    i = 0;
    while (!out_valid && i < budget) begin
      tick();
      i++;
    end
    chk("valid_wait", 128'(out_valid), 128'(1));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; out_ready = 1'b0; mul_in = '0;
    idle(LAT);
    do_reset();
    chk("rst_sum",   128'(out_sum),   128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_ovf",   128'(out_ovf),   128'(0));
    chk("rst_drop",  128'(drop_err),  128'(0));
    chk("rst_cnt",   128'(acc_cnt),   128'(0));

    // latency: one enable, consumed exactly LAT edges later
    idle(5);
    issue(65'd1);
    repeat (LAT - 1) begin
      tick();
      chk("lat_early", 128'(acc_cnt), 128'(0));
    end
    tick();
    chk("lat_cnt", 128'(acc_cnt), 128'(1));

    // full batch 1..8
    do_reset();
    out_ready = 1'b1;
    for (int v = 1; v <= BATCH; v++) issue(65'(v));
    wait_valid(LAT + 4);
    chk("batch_sum", 128'(out_sum), 128'(36));
    chk("batch_ovf", 128'(out_ovf), 128'(0));
    tick();
    chk("batch_pulse", 128'(out_valid), 128'(0));

    // negative products: fits in 72 bits, wraps in 66 bits
    do_reset();
    out_ready = 1'b1;
    repeat (BATCH) issue(NEG);
    wait_valid(LAT + 4);
    chk("neg_sum",   128'(out_sum),   128'(72'hF8_0000_0000_0000_0000));
    chk("neg_ovf",   128'(out_ovf),   128'(0));
    chk("neg_sum66", 128'(out_sum66), 128'(0));
    chk("neg_ovf66", 128'(out_ovf66), 128'(1));
    tick();

    // backpressure across two batches: second is dropped
    do_reset();
    out_ready = 1'b0;
    for (int v = 1; v <= 2 * BATCH; v++) issue(65'(v));
    idle(LAT + 1);
    chk("bp_sum",   128'(out_sum),   128'(36));
    chk("bp_valid", 128'(out_valid), 128'(1));
    chk("bp_drop",  128'(drop_err),  128'(1));
    out_ready = 1'b1;
    tick();
    chk("bp_drain", 128'(out_valid), 128'(0));

    // drain and reload on the same edge
    do_reset();
    out_ready = 1'b0;
    for (int v = 1; v <= 2 * BATCH; v++) issue(65'(v));
    idle(LAT - 1);
    out_ready = 1'b1;
    tick();
    chk("sim_valid", 128'(out_valid), 128'(1));
    chk("sim_sum",   128'(out_sum),   128'(100));
    chk("sim_drop",  128'(drop_err),  128'(0));
    tick();
    chk("sim_drain", 128'(out_valid), 128'(0));

    // clear coinciding with fresh product 5 at acc_cnt=3
    do_reset();
    out_ready = 1'b1;
    issue(65'd1); issue(65'd2); issue(65'd3); issue(65'd5);
    idle(LAT - 1);
    chk("clr_pre", 128'(acc_cnt), 128'(3));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_cnt", 128'(acc_cnt), 128'(1));
    for (int v = 1; v < BATCH; v++) issue(65'(10 * v));
    wait_valid(LAT + 4);
    chk("clr_sum", 128'(out_sum), 128'(285));
    tick();

    // reset with products in flight
    do_reset();
    repeat (3) issue(65'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(LAT + 2);
    chk("mid_cnt",   128'(acc_cnt),   128'(0));
    chk("mid_valid", 128'(out_valid), 128'(0));
    chk("mid_drop",  128'(drop_err),  128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
